gio_int_ctrl: RTL

- Interrupt controller directly downstream of the interrupt-on-change input ports.
- Collects N single-bit interrupt sources (e.g. int_out of IOC ports), latches rising edges into a pending register and gates them with a mask.
- Drives the PicoBlaze interrupt line and handles its interrupt_ack handshake.
- Exposes mask, pending and source-ID registers on the port bus; readback goes through the input port selector.

---
 rtl/gio_pkg.sv | 26 ++
 rtl/gio_prio_enc.sv | 24 ++
 rtl/gio_int_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gio_pkg.sv
// Shared definitions for the GPIO interrupt controller.
// Contents: FSM state encoding, default port-bus register addresses,
//           position of the valid bit in the source-ID register, ID word helper.
package gio_pkg;

  // Controller FSM: waiting for work, interrupt raised, CPU inside its ISR.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } gio_state_e;

  // Default port-bus addresses of the controller registers.
  localparam logic [7:0] GIO_ADDR_MASK = 8'h10;
  localparam logic [7:0] GIO_ADDR_PEND = 8'h11;
  localparam logic [7:0] GIO_ADDR_ID   = 8'h12;

  // Bit 7 of the ID register flags a capture the CPU has not read yet.
  localparam int ID_VLD_BIT = 7;

  // ID register format: {valid, 4'b0, source index}.
  function automatic logic [7:0] gio_id_word(input logic [2:0] idx);
    return {1'b1, 4'b0000, idx};
  endfunction

endpackage

// File: rtl/gio_prio_enc.sv
// Lowest-set-bit priority encoder (index 0 has the highest priority).
// Latency: purely combinational. Backpressure: none.
// Ports: req (N request bits) -> idx (3-bit index of lowest set bit, 0 if none), any (|req).
module gio_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gio_int_ctrl.sv
// Interrupt controller: latches rising edges of N sources into pending, masks them,
//   drives the CPU interrupt line and captures the serviced source ID.
// Latency: source high at edge P0 sets pending at P0, interrupt rises at P1; reads land in port_out one edge after ren.
// Backpressure: none; the CPU paces the flow through interrupt_ack and register writes.
// Ports: clk/rst (async active-low), address/value_in/wen/ren port bus, int_src sources,
//        interrupt/interrupt_ack CPU handshake, port_out registered read data.
module gio_int_ctrl
  import gio_pkg::*;
#(
  parameter int         N         = 4,
  parameter logic [7:0] ADDR_MASK = GIO_ADDR_MASK,
  parameter logic [7:0] ADDR_PEND = GIO_ADDR_PEND,
  parameter logic [7:0] ADDR_ID   = GIO_ADDR_ID
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   address,
  input  logic [7:0]   value_in,
  input  logic         wen,
  input  logic         ren,
  input  logic [N-1:0] int_src,
  output logic         interrupt,
  input  logic         interrupt_ack,
  output logic [7:0]   port_out
);

  logic [N-1:0] src_q, src_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q, mask_d;
  logic [7:0]   id_q, id_d;
  logic [7:0]   port_q, port_d;
  logic         int_q, int_d;
  gio_state_e   state_q, state_d;

  logic [N-1:0] rise;
  logic [N-1:0] masked;
  logic [2:0]   prio_idx;
  logic         active;
  logic         wr_mask, wr_pend, rd_en;
  logic         capture;
  logic [7:0]   mask_ext, pend_ext;

  // Upper write-data bits beyond N have no storage.
  logic unused_value_in;
  assign unused_value_in = ^value_in;

  assign wr_mask = wen && (address == ADDR_MASK);
  assign wr_pend = wen && (address == ADDR_PEND);
  // A write in the same cycle suppresses the read entirely.
  assign rd_en   = ren && !wen;

  assign rise   = int_src & ~src_q;
  assign masked = pend_q & mask_q;

  gio_prio_enc #(.N(N)) u_prio (
    .req (masked),
    .idx (prio_idx),
    .any (active)
  );

  always_comb begin
    mask_ext = 8'h00;
    pend_ext = 8'h00;
    mask_ext[N-1:0] = mask_q;
    pend_ext[N-1:0] = pend_q;
  end

  // Source tracking, pending (set beats W1C) and mask.
  always_comb begin
    src_d  = int_src;
    pend_d = rise | (pend_q & ~(wr_pend ? value_in[N-1:0] : {N{1'b0}}));
    mask_d = wr_mask ? value_in[N-1:0] : mask_q;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        // Losing the request wins over a coincident ack: nothing is left to service.
        if (!active)           state_d = ST_IDLE;
        else if (interrupt_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        // Any write to pending or mask marks the end of the ISR.
        if (wr_pend || wr_mask) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: registered interrupt line and ID capture strobe.
  always_comb begin
    int_d   = (state_d == ST_ASSERT);
    capture = (state_q == ST_ASSERT) && active && interrupt_ack;
  end

  // Read path and ID register.
  always_comb begin
    port_d = port_q;
    id_d   = id_q;
    if (rd_en) begin
      if (address == ADDR_MASK) begin
        port_d = mask_ext;
      end else if (address == ADDR_PEND) begin
        port_d = pend_ext;
      end else if (address == ADDR_ID) begin
        // Return the value as it was, then drop valid so a re-read shows it consumed.
        port_d            = id_q;
        id_d[ID_VLD_BIT]  = 1'b0;
      end
    end
    if (capture) id_d = gio_id_word(prio_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      id_q    <= 8'h00;
      port_q  <= 8'h00;
      int_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      src_q   <= src_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      port_q  <= port_d;
      int_q   <= int_d;
      state_q <= state_d;
    end
  end

  assign interrupt = int_q;
  assign port_out  = port_q;

endmodule
